// File: rtl/cmem_arb_if.sv
// cmem_arb_if: bundle of the requester-side and cmem-side signals of the
// shared cmem port arbiter.
//   requesters : i_* (imem refill read), d_* (dmem refill read), w_* (store)
//   cmem       : c_addr/c_len/c_wdata/c_rd/c_wr out, c_dv/c_rdata in
//   status     : rdata, err, timeout_err, err_clr
// modport slave  - the arbiter side
// modport master - the requester/cmem environment side
interface cmem_arb_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_done;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_done;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_len;
  logic [63:0]       w_wdata;
  logic              w_gnt;
  logic              w_done;
  logic [ADDR_W-1:0] c_addr;
  logic [2:0]        c_len;
  logic [63:0]       c_wdata;
  logic              c_rd;
  logic              c_wr;
  logic              c_dv;
  logic [LINE_W-1:0] c_rdata;
  logic [LINE_W-1:0] rdata;
  logic              err;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, w_req, w_addr, w_len, w_wdata,
           c_dv, c_rdata, err_clr,
    output i_gnt, i_done, d_gnt, d_done, w_gnt, w_done,
           c_addr, c_len, c_wdata, c_rd, c_wr, rdata, err, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, w_req, w_addr, w_len, w_wdata,
           c_dv, c_rdata, err_clr,
    input  i_gnt, i_done, d_gnt, d_done, w_gnt, w_done,
           c_addr, c_len, c_wdata, c_rd, c_wr, rdata, err, timeout_err
  );
endinterface

// File: rtl/cmem_arb.sv
// cmem_arb: arbiter/sequencer for the shared cmem port.
// Three requesters (imem read, dmem read, store write) share one path into
// cmem. Round-robin I->D->W with a store-before-load override when the store
// and the dmem read hit the same line. One transaction in flight; a watchdog
// terminates transactions that see no c_dv within TIMEOUT busy cycles.
// Ports:
//   clk   - clock
//   rst_n - async active-low reset
//   bus   - cmem_arb_if.slave (requester handshakes, cmem strobes, status)
//
// state     | meaning
// ST_IDLE   | waiting for a request; arbitrates each cycle
// ST_BUSY   | transaction issued to cmem; waiting for c_dv or timeout
// ST_DONE   | one-cycle completion; no grant so the requester can drop req
module cmem_arb #(
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 512,
  parameter int OFFS_W  = 6,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst_n,
  cmem_arb_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_W = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_sel;
  logic [1:0]        r_rr_last;
  logic              r_first;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_len;
  logic [63:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_rdata;
  logic              r_to;
  logic              r_to_sticky;

  logic              w_same_line;
  logic              w_d_eff;
  logic              w_any;
  logic [1:0]        w_win;
  logic              w_to_hit;
  logic              w_grant;

  // A store to the same line as a pending dmem read masks the read so the
  // load observes the stored data.
  assign w_same_line = (bus.w_addr[ADDR_W-1:OFFS_W] == bus.d_addr[ADDR_W-1:OFFS_W]);
  assign w_d_eff     = bus.d_req && !(bus.w_req && w_same_line);
  assign w_any       = bus.i_req || w_d_eff || bus.w_req;
  assign w_grant     = (r_state == ST_IDLE) && w_any;
  // c_dv takes precedence over a coincident timeout.
  assign w_to_hit    = (TIMEOUT != 0) && (r_state == ST_BUSY) && !bus.c_dv && (r_cnt == TO_C);

  always_comb begin
    w_win = SRC_I;
    case (r_rr_last)
      SRC_I: begin
        if (w_d_eff)         w_win = SRC_D;
        else if (bus.w_req)  w_win = SRC_W;
        else                 w_win = SRC_I;
      end
      SRC_D: begin
        if (bus.w_req)       w_win = SRC_W;
        else if (bus.i_req)  w_win = SRC_I;
        else                 w_win = SRC_D;
      end
      default: begin
        if (bus.i_req)       w_win = SRC_I;
        else if (w_d_eff)    w_win = SRC_D;
        else                 w_win = SRC_W;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (bus.c_dv || w_to_hit) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // transaction datapath, watchdog and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= SRC_I;
      r_rr_last   <= SRC_W;
      r_first     <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_to        <= 1'b0;
      r_to_sticky <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (w_grant) begin
        r_sel     <= w_win;
        r_rr_last <= w_win;
        r_first   <= 1'b1;
        r_cnt     <= '0;
        r_to      <= 1'b0;
        case (w_win)
          SRC_I: begin
            r_addr  <= bus.i_addr;
            r_len   <= '0;
            r_wdata <= '0;
          end
          SRC_D: begin
            r_addr  <= bus.d_addr;
            r_len   <= '0;
            r_wdata <= '0;
          end
          default: begin
            r_addr  <= bus.w_addr;
            r_len   <= bus.w_len;
            r_wdata <= bus.w_wdata;
          end
        endcase
      end
      if (r_state == ST_BUSY) begin
        r_to <= w_to_hit;
        if (!bus.c_dv && (r_cnt != TO_C)) r_cnt <= r_cnt + CNT_W'(1);
        if (bus.c_dv && (r_sel != SRC_W)) r_rdata <= bus.c_rdata;
      end
      // a new timeout beats a simultaneous clear
      if (w_to_hit)         r_to_sticky <= 1'b1;
      else if (bus.err_clr) r_to_sticky <= 1'b0;
    end
  end

  // outputs
  always_comb begin
    bus.c_rd        = (r_state == ST_BUSY) && (r_sel != SRC_W);
    bus.c_wr        = (r_state == ST_BUSY) && (r_sel == SRC_W);
    bus.i_gnt       = (r_state == ST_BUSY) && r_first && (r_sel == SRC_I);
    bus.d_gnt       = (r_state == ST_BUSY) && r_first && (r_sel == SRC_D);
    bus.w_gnt       = (r_state == ST_BUSY) && r_first && (r_sel == SRC_W);
    bus.i_done      = (r_state == ST_DONE) && (r_sel == SRC_I);
    bus.d_done      = (r_state == ST_DONE) && (r_sel == SRC_D);
    bus.w_done      = (r_state == ST_DONE) && (r_sel == SRC_W);
    bus.err         = (r_state == ST_DONE) && r_to;
    bus.c_addr      = r_addr;
    bus.c_len       = r_len;
    bus.c_wdata     = r_wdata;
    bus.rdata       = r_rdata;
    bus.timeout_err = r_to_sticky;
  end
endmodule
